// File: rtl/div_iter_pkg.sv
// Shared divider handshake levels, state encoding and a sign helper.
package div_iter_pkg;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
// Purely combinational.
module div_step (
  input  logic [32:0] r_i,
  input  logic        msb_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] r_o,
  output logic        q_o
);

  logic [33:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {r_i, msb_i};
    diff    = shifted[32:0] - {1'b0, divisor_i};
    q_o     = (shifted >= {2'b00, divisor_i});
    r_o     = q_o ? diff : shifted[32:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per cycle; ready 33 cycles after start.
// Result held while start_i stays high. DIV_ZERO_FAST_EN: divide-by-zero finishes early with a zero result.
module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dq_q, dq_d;     // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] r_q, r_d;
  logic        s1_q, s1_d, s2_q, s2_d, sgn_q, sgn_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] step_r;
  logic        step_q;
  logic        zero_fast;
  logic [31:0] quot_fin;

  div_step u_step (
    .r_i       (r_q),
    .msb_i     (dq_q[31]),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (dvs_q == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif

  assign quot_fin = {dq_q[30:0], step_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dq_d     = dq_q;
    dvs_d    = dvs_q;
    r_d      = r_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (start_i == DivStart && !annul_i) begin
          state_d = DIV_BUSY;
          sgn_d   = signed_div_i;
          s1_d    = signed_div_i & opdata1_i[31];
          s2_d    = signed_div_i & opdata2_i[31];
          dq_d    = neg_if(s1_d, opdata1_i);
          dvs_d   = neg_if(s2_d, opdata2_i);
          r_d     = '0;
          cnt_d   = '0;
        end
      end
      DIV_BUSY: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else if (zero_fast) begin
          state_d  = DIV_DONE;
          ready_d  = DivResultReady;
          result_d = '0;
        end else begin
          r_d   = step_r;
          dq_d  = quot_fin;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DIV_DONE;
            ready_d  = DivResultReady;
            // Remainder takes the dividend's sign; quotient is negative when signs differ.
            result_d = {neg_if(s1_q, step_r[31:0]),
                        neg_if(sgn_q & (s1_q ^ s2_q), quot_fin)};
          end
        end
      end
      DIV_DONE: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DIV_IDLE;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: begin
        state_d  = DIV_IDLE;
        ready_d  = DivResultNotReady;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      dq_q     <= '0;
      dvs_q    <= '0;
      r_q      <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      dvs_q    <= dvs_d;
      r_q      <= r_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases from the plan plus randomized divides against an arithmetic model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_assert = 0;
  int n_fail   = 0;

  div_iter dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero gives all-ones quotient magnitude
  // and the dividend magnitude as remainder, then the usual sign rules.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] am, q32, r32;
    bit neg_a, neg_b;
    neg_a = sgn && a[31];
    neg_b = sgn && b[31];
    if (b == 32'd0) begin
      am  = neg_a ? (32'd0 - a) : a;
      q32 = (neg_a != neg_b) ? 32'h1 : 32'hFFFF_FFFF;
      r32 = neg_a ? (32'd0 - am) : am;
      return {r32, q32};
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold, input string tag);
    int cyc;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    cyc = 0;
    while (cyc < 40 && ready_o !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " result"}, result_o, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold ready"}, {63'd0, ready_o}, 64'd1);
      check({tag, " hold result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop ready"}, {63'd0, ready_o}, 64'd0);
    check({tag, " drop result"}, result_o, 64'd0);
  endtask

  initial begin
    int bad;
    bit sgn;
    logic [31:0] a, b;

    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    #1;
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 0, "u100/7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, "s-7/2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0, "smin/-1");
    run_div(1'b0, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF}, 0, "u5/0");
    run_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, model(1'b0, 32'hDEAD_BEEF, 32'h0000_1234), 5, "hold");

    // Annul at BUSY cycle 10: result must never appear.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1; annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1; annul_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) bad++;
    end
    check("annul no ready", 64'(bad), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 0, "u9/3 after annul");

    // Reset mid-BUSY, then reset while a result is held.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #2; resetn = 1'b0; #1;
    check("rst busy ready", {63'd0, ready_o}, 64'd0);
    check("rst busy result", result_o, 64'd0);
    @(negedge clk); start_i = 1'b0; resetn = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 0, "u100/7 after rst");

    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FF00; opdata2_i = 32'd3; start_i = 1'b1;
    bad = 0;
    while (bad < 40 && ready_o !== 1'b1) begin @(posedge clk); #1; bad++; end
    check("pre-rst done result", result_o, model(1'b1, 32'hFFFF_FF00, 32'd3));
    #2; resetn = 1'b0; #1;
    check("rst done ready", {63'd0, ready_o}, 64'd0);
    check("rst done result", result_o, 64'd0);
    @(negedge clk); start_i = 1'b0; resetn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'd0 - $urandom_range(1, 100);
        default: b = (i % 5 == 0) ? 32'd0 : ($urandom >> 16);
      endcase
      run_div(sgn, a, b, model(sgn, a, b), i % 3, $sformatf("rand%0d %0d:%h/%h", i, sgn, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
